decode_ctrl_pipe: RTL

Registered, parametrised MIPS main-decode stage. It replaces the purely combinational main decoder between ID and EX. It decodes the full 32-bit instruction into a wider control bundle covering link/JR, memory size and sign, and HI/LO source. It holds the bundle in a valid/ready pipeline register and interlocks HI/LO consumers behind multi-cycle MULT/DIV using a latency counter.

---
 rtl/decode_ctrl_pipe_pkg.sv | 110 +++++++++++
 rtl/decode_ctrl_pipe_ctrl_decode_comb.sv | 114 +++++++++++
 rtl/decode_ctrl_pipe.sv | 108 ++++++++++
 3 files changed

// File: rtl/decode_ctrl_pipe_pkg.sv
// Shared encodings for the registered MIPS main-decode stage: opcode/funct/REGIMM-rt
// values, control-field encodings, default HI/LO latencies and the control bundle type.
package decode_ctrl_pipe_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0a;
    localparam logic [5:0] OP_SLTIU   = 6'h0b;
    localparam logic [5:0] OP_ANDI    = 6'h0c;
    localparam logic [5:0] OP_ORI     = 6'h0d;
    localparam logic [5:0] OP_XORI    = 6'h0e;
    localparam logic [5:0] OP_LUI     = 6'h0f;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SW      = 6'h2b;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_DIVU  = 6'h1b;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2a;
    localparam logic [5:0] FN_SLTU  = 6'h2b;

    localparam logic [4:0] RT_BLTZ   = 5'h00;
    localparam logic [4:0] RT_BGEZ   = 5'h01;
    localparam logic [4:0] RT_BLTZAL = 5'h10;
    localparam logic [4:0] RT_BGEZAL = 5'h11;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] MSIZE_B = 2'b00;
    localparam logic [1:0] MSIZE_H = 2'b01;
    localparam logic [1:0] MSIZE_W = 2'b10;

    localparam logic [1:0] HILOSRC_GPR = 2'b00;
    localparam logic [1:0] HILOSRC_MUL = 2'b01;
    localparam logic [1:0] HILOSRC_DIV = 2'b10;

    localparam logic [1:0] HILORD_NONE = 2'b00;
    localparam logic [1:0] HILORD_LO   = 2'b01;
    localparam logic [1:0] HILORD_HI   = 2'b11;

    localparam int DEF_MUL_LAT = 2;
    localparam int DEF_DIV_LAT = 36;
    localparam int DEF_CNT_W   = 6;

    typedef struct packed {
        logic       regwrite;
        logic [1:0] regdst;
        logic       alusrc;
        logic       branch;
        logic       jump;
        logic       jr;
        logic       link;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic [1:0] mem_size;
        logic       mem_sext;
        logic [1:0] hilo_we;
        logic [1:0] hilo_src;
        logic [1:0] hilo_rd;
        logic       md_start;
        logic       illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // Any SPECIAL funct that touches HI/LO and so must wait for the multiplier/divider.
    function automatic logic is_md_funct(input logic [5:0] fn);
        return (fn == FN_MULT) || (fn == FN_MULTU) || (fn == FN_DIV) || (fn == FN_DIVU) ||
               (fn == FN_MTHI) || (fn == FN_MTLO) || (fn == FN_MFHI) || (fn == FN_MFLO);
    endfunction

endpackage

// File: rtl/decode_ctrl_pipe_ctrl_decode_comb.sv
// Pure combinational MIPS main decode: instruction word to control bundle plus HI/LO-op flag.
// DECODE_RI_TRAP_EN: undefined op/funct raise illegal instead of decoding as NOP/R-type.
module ctrl_decode_comb
    import decode_ctrl_pipe_pkg::*;
(
    input  logic [31:0] instr,
    output ctrl_t       ctrl,
    output logic        md_op
);

    logic [5:0] op;
    logic [4:0] rt;
    logic [5:0] funct;
    logic       unused_fields;

    assign op            = instr[31:26];
    assign rt            = instr[20:16];
    assign funct         = instr[5:0];
    assign unused_fields = &{1'b0, instr[25:21], instr[15:6]};

    assign md_op = (op == OP_SPECIAL) && is_md_funct(funct);

    always_comb begin
        ctrl = CTRL_NOP;
        case (op)
            OP_SPECIAL: begin
                case (funct)
                    FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
                    FN_XOR, FN_NOR, FN_SLT, FN_SLTU: begin
                        ctrl.regwrite = 1'b1;
                        ctrl.regdst   = REGDST_RD;
                    end
                    FN_JR: ctrl.jr = 1'b1;
                    FN_JALR: begin
                        ctrl.regwrite = 1'b1;
                        ctrl.regdst   = REGDST_RD;
                        ctrl.link     = 1'b1;
                        ctrl.jr       = 1'b1;
                    end
                    FN_MFHI, FN_MFLO: begin
                        ctrl.regwrite = 1'b1;
                        ctrl.regdst   = REGDST_RD;
                        ctrl.hilo_rd  = (funct == FN_MFHI) ? HILORD_HI : HILORD_LO;
                    end
                    FN_MTHI: ctrl.hilo_we = 2'b10;
                    FN_MTLO: ctrl.hilo_we = 2'b01;
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                        ctrl.hilo_we  = 2'b11;
                        ctrl.hilo_src = funct[1] ? HILOSRC_DIV : HILOSRC_MUL;
                        ctrl.md_start = 1'b1;
                    end
                    default: begin
`ifdef DECODE_RI_TRAP_EN
                        ctrl.illegal  = 1'b1;
`else
                        ctrl.regwrite = 1'b1;
                        ctrl.regdst   = REGDST_RD;
`endif
                    end
                endcase
            end
            OP_REGIMM: begin
                case (rt)
                    RT_BLTZ, RT_BGEZ: ctrl.branch = 1'b1;
                    RT_BLTZAL, RT_BGEZAL: begin
                        ctrl.branch   = 1'b1;
                        ctrl.link     = 1'b1;
                        ctrl.regwrite = 1'b1;
                        ctrl.regdst   = REGDST_RA;
                    end
                    default: begin
`ifdef DECODE_RI_TRAP_EN
                        ctrl.illegal = 1'b1;
`endif
                    end
                endcase
            end
            OP_J: ctrl.jump = 1'b1;
            OP_JAL: begin
                ctrl.jump     = 1'b1;
                ctrl.link     = 1'b1;
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = REGDST_RA;
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: ctrl.branch = 1'b1;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                ctrl.regwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.regdst   = REGDST_RT;
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                ctrl.regwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.memread  = 1'b1;
                ctrl.memtoreg = 1'b1;
                ctrl.mem_size = (op == OP_LW) ? MSIZE_W :
                                ((op == OP_LH) || (op == OP_LHU)) ? MSIZE_H : MSIZE_B;
                ctrl.mem_sext = (op == OP_LB) || (op == OP_LH) || (op == OP_LW);
            end
            OP_SB, OP_SH, OP_SW: begin
                ctrl.alusrc   = 1'b1;
                ctrl.memwrite = 1'b1;
                ctrl.mem_size = (op == OP_SW) ? MSIZE_W : (op == OP_SH) ? MSIZE_H : MSIZE_B;
            end
            default: begin
`ifdef DECODE_RI_TRAP_EN
                ctrl.illegal = 1'b1;
`endif
            end
        endcase
    end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// Registered main-decode stage with valid/ready handshake and HI/LO busy interlock.
// DECODE_RI_TRAP_EN (in the decoder) enables the reserved-instruction flag.
module decode_ctrl_pipe
    import decode_ctrl_pipe_pkg::*;
#(
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int DIV_LAT = DEF_DIV_LAT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        regwrite,
    output logic [1:0]  regdst,
    output logic        alusrc,
    output logic        branch,
    output logic        jump,
    output logic        jr,
    output logic        link,
    output logic        memread,
    output logic        memwrite,
    output logic        memtoreg,
    output logic [1:0]  mem_size,
    output logic        mem_sext,
    output logic [1:0]  hilo_we,
    output logic [1:0]  hilo_src,
    output logic [1:0]  hilo_rd,
    output logic        md_start,
    output logic        illegal,
    output logic        md_busy
);

    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);

    ctrl_t             ctrl_p0;
    logic              md_op_p0;
    ctrl_t             ctrl_p1;
    logic              vld_p1;
    logic [CNT_W-1:0]  busy_cnt;
    logic              hazard;
    logic              accept;
    logic              md_issue;

    ctrl_decode_comb u_dec (
        .instr (instr),
        .ctrl  (ctrl_p0),
        .md_op (md_op_p0)
    );

    // Busy also covers the cycle a MULT/DIV sits in the register before EX takes it.
    assign md_busy  = (busy_cnt != '0) || (vld_p1 && ctrl_p1.md_start);
    assign hazard   = md_busy && md_op_p0;
    assign in_ready = (!vld_p1 || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;
    assign md_issue = vld_p1 && out_ready && ctrl_p1.md_start;

    // ---- p0 -> p1 : pipeline register
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_p1  <= 1'b0;
            ctrl_p1 <= CTRL_NOP;
        end else if (flush) begin
            vld_p1  <= 1'b0;
        end else if (accept) begin
            vld_p1  <= 1'b1;
            ctrl_p1 <= ctrl_p0;
        end else if (out_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    // A flush does not stop an already-launched MULT/DIV, so the counter keeps running.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_cnt <= '0;
        end else if (md_issue) begin
            busy_cnt <= (ctrl_p1.hilo_src == HILOSRC_DIV) ? DIV_CNT : MUL_CNT;
        end else if (busy_cnt != '0) begin
            busy_cnt <= busy_cnt - CNT_W'(1);
        end
    end

    assign out_valid = vld_p1;
    assign regwrite  = ctrl_p1.regwrite;
    assign regdst    = ctrl_p1.regdst;
    assign alusrc    = ctrl_p1.alusrc;
    assign branch    = ctrl_p1.branch;
    assign jump      = ctrl_p1.jump;
    assign jr        = ctrl_p1.jr;
    assign link      = ctrl_p1.link;
    assign memread   = ctrl_p1.memread;
    assign memwrite  = ctrl_p1.memwrite;
    assign memtoreg  = ctrl_p1.memtoreg;
    assign mem_size  = ctrl_p1.mem_size;
    assign mem_sext  = ctrl_p1.mem_sext;
    assign hilo_we   = ctrl_p1.hilo_we;
    assign hilo_src  = ctrl_p1.hilo_src;
    assign hilo_rd   = ctrl_p1.hilo_rd;
    assign md_start  = ctrl_p1.md_start;
    assign illegal   = ctrl_p1.illegal;

endmodule
